// File: rtl/apb_master_bridge.sv
//------------------------------------------------------------------------------
// apb_master_bridge : req/gnt/rvalid to APB3/APB4 initiator bridge with PREADY timeout
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic                        we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] be_i,
  input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
  output logic                        rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
  output logic                        pwrite_o,
  output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
  output logic                        psel_o,
  output logic                        penable_o,
  input  logic                        pready_i,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
  input  logic                        pslverr_i
);

  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int STRB_W = APB_DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_rvalid;
  logic [APB_DATA_WIDTH-1:0]  r_rdata;
  logic                       r_err;
  logic [APB_ADDR_WIDTH-1:0]  r_paddr;
  logic [APB_DATA_WIDTH-1:0]  r_pwdata;
  logic                       r_pwrite;
  logic [STRB_W-1:0]          r_pstrb;
  logic                       r_psel;
  logic                       r_penable;
  logic                       w_gnt;
  logic                       w_timeout;

  // Gated by rst_ni so that every output reads 0 while reset is held.
  assign w_gnt     = req_i && rst_ni && (r_state == S_IDLE);
  // r_cnt holds the number of earlier low-PREADY ACCESS cycles, so the
  // current cycle is the limit-th one when it equals TIMEOUT_CYCLES-1.
  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_pstrb   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_paddr  <= addr_i;
            r_pwdata <= wdata_i;
            r_pwrite <= we_i;
            r_pstrb  <= we_i ? be_i : '0;
            r_psel   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready_i) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b1;
            r_err     <= pslverr_i;
            r_rdata   <= (!r_pwrite && !pslverr_i) ? prdata_i : '0;
            r_state   <= S_IDLE;
          end else if (w_timeout) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_o     = w_gnt;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign err_o     = r_err;
  assign paddr_o   = r_paddr;
  assign pwdata_o  = r_pwdata;
  assign pwrite_o  = r_pwrite;
  assign pstrb_o   = r_pstrb;
  assign psel_o    = r_psel;
  assign penable_o = r_penable;

endmodule

`default_nettype wire
